level_update_arbiter: RTL

//   Shares a single saturating level adder among the three encoder channels of the RGB mixer.
//   Per-channel inc/dec pulses from the quadrature decoders are buffered as signed pending counts.
//   A round-robin arbiter retires one step per cycle into the shadow level registers.

---
 rtl/level_update_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/level_update_arbiter.sv
// Three-channel level mixer. Buffered inc/dec events share one saturating adder through a
// round-robin arbiter. Shadow levels are copied to the duty outputs only on frame_start.
module level_update_arbiter #(
    parameter int WIDTH  = 8,
    parameter int STEP   = 1,
    parameter int PEND_W = 4,
    parameter int WRAP   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         inc,
    input  logic [2:0]         dec,
    input  logic               frame_start,
    output logic [3*WIDTH-1:0] level_o,
    output logic [2:0]         grant,
    output logic               busy,
    output logic [2:0]         drop
);

    typedef logic [PEND_W-1:0] pend_t;
    typedef logic [WIDTH-1:0]  lvl_t;

    localparam logic [PEND_W:0] P_ONE   = {{PEND_W{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]  STEP_X  = (WIDTH+1)'(STEP);
    localparam lvl_t            LVL_MAX = {WIDTH{1'b1}};
    localparam lvl_t            LVL_MIN = {WIDTH{1'b0}};

    pend_t              pend_q   [3];
    pend_t              pend_d   [3];
    lvl_t               shadow_q [3];
    lvl_t               shadow_d [3];
    logic [3*WIDTH-1:0] level_q, level_d;
    logic [2:0]         drop_q, drop_d;
    logic [1:0]         last_q, last_d;
    logic [2:0]         cand_s;
    logic [2:0]         grant_s;
    logic [PEND_W:0]    pend_x_s, retired_s, next_s;

    // Search order starts one past the previous winner.
    function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
        logic [2:0] g;
        g = 3'b000;
        case (last)
            2'd0: begin
                if (cand[1]) g = 3'b010;
                else if (cand[2]) g = 3'b100;
                else if (cand[0]) g = 3'b001;
                else g = 3'b000;
            end
            2'd1: begin
                if (cand[2]) g = 3'b100;
                else if (cand[0]) g = 3'b001;
                else if (cand[1]) g = 3'b010;
                else g = 3'b000;
            end
            default: begin
                if (cand[0]) g = 3'b001;
                else if (cand[1]) g = 3'b010;
                else if (cand[2]) g = 3'b100;
                else g = 3'b000;
            end
        endcase
        return g;
    endfunction

    function automatic logic [1:0] grant_idx(input logic [2:0] g, input logic [1:0] last);
        logic [1:0] idx;
        case (g)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = last;
        endcase
        return idx;
    endfunction

    // WIDTH+1 bit arithmetic; the carry/borrow bit flags an out-of-range result.
    function automatic lvl_t shadow_step(input lvl_t cur, input logic down);
        logic [WIDTH:0] s;
        lvl_t           r;
        if (down) s = {1'b0, cur} - STEP_X;
        else      s = {1'b0, cur} + STEP_X;
        if (s[WIDTH] && (WRAP == 32'sd0)) r = down ? LVL_MIN : LVL_MAX;
        else                              r = s[WIDTH-1:0];
        return r;
    endfunction

    assign grant   = grant_s;
    assign busy    = |cand_s;
    assign level_o = level_q;
    assign drop    = drop_q;

    // Arbitration, pending bookkeeping, shadow update and frame load.
    always_comb begin
        pend_x_s  = {(PEND_W+1){1'b0}};
        retired_s = {(PEND_W+1){1'b0}};
        next_s    = {(PEND_W+1){1'b0}};
        drop_d    = 3'b000;
        for (int c = 0; c < 3; c++) begin
            cand_s[c] = |pend_q[c];
        end
        grant_s = rr_pick(cand_s, last_q);
        last_d  = grant_idx(grant_s, last_q);
        for (int c = 0; c < 3; c++) begin
            pend_x_s = {pend_q[c][PEND_W-1], pend_q[c]};
            if (grant_s[c]) begin
                if (pend_q[c][PEND_W-1]) retired_s = pend_x_s + P_ONE;
                else                     retired_s = pend_x_s - P_ONE;
                shadow_d[c] = shadow_step(shadow_q[c], pend_q[c][PEND_W-1]);
            end else begin
                retired_s   = pend_x_s;
                shadow_d[c] = shadow_q[c];
            end
            if (inc[c] && !dec[c])      next_s = retired_s + P_ONE;
            else if (dec[c] && !inc[c]) next_s = retired_s - P_ONE;
            else                        next_s = retired_s;
            // Top two bits disagree only when the new event pushed past the signed range.
            if (next_s[PEND_W] != next_s[PEND_W-1]) begin
                pend_d[c] = retired_s[PEND_W-1:0];
                drop_d[c] = 1'b1;
            end else begin
                pend_d[c] = next_s[PEND_W-1:0];
                drop_d[c] = 1'b0;
            end
        end
        if (frame_start) level_d = {shadow_q[2], shadow_q[1], shadow_q[0]};
        else             level_d = level_q;
    end

    // State registers; last winner resets to channel 2 so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                pend_q[c]   <= {PEND_W{1'b0}};
                shadow_q[c] <= {WIDTH{1'b0}};
            end
            level_q <= {(3*WIDTH){1'b0}};
            drop_q  <= 3'b000;
            last_q  <= 2'd2;
        end else begin
            for (int c = 0; c < 3; c++) begin
                pend_q[c]   <= pend_d[c];
                shadow_q[c] <= shadow_d[c];
            end
            level_q <= level_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
        end
    end

endmodule
